pio_in_capture: RTL and testbench

- Avalon-MM slave parallel-input port; the input-direction counterpart to the system's 8-bit PIO output.
- Samples external pins through a two-flop synchronizer and latches edge events per bit.
- Raises a level interrupt to the KyogenRV core through the fabric.
- Sits inside the FPGA top, between the board pins and the Qsys interconnect, on the core clock domain.

---
 rtl/pio_in_capture.sv | 141 ++++++++++++++
 tb/tb_pio_in_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_capture.sv
// Avalon-MM parallel-input port: synchronised pins, per-bit edge capture, masked level irq.
// Define PIO_IN_DEBOUNCE_EN to insert a per-bit stability filter of DEB_CYCLES clocks.
module pio_in_capture #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEB_CYCLES = 24000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned ARM_W = 4;
`else
    localparam int unsigned ARM_W = 3;
`endif

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_esel;
    logic [ARM_W-1:0] r_arm;

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;

    // r_arm fills with ones after reset; edge detect waits until the previous-sample
    // register holds a real pin value, so a high pin at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_arm <= '0;
        end else begin
            r_s1  <= pins_in;
            r_s2  <= r_s1;
            r_arm <= {r_arm[ARM_W-2:0], 1'b1};
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0] r_deb;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // The filter preloads from s2 during warm-up, then only follows a stable input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else if (!r_arm[ARM_W-2]) begin
            r_deb <= r_s2;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEB_CYCLES)) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_cur = r_deb;
`else
    logic w_unused_deb;

    assign w_cur        = r_s2;
    assign w_unused_deb = (DEB_CYCLES == 0);
`endif

    assign w_rise = w_cur & ~r_prev;
    assign w_fall = ~w_cur & r_prev;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
        if (gi < 16) begin : g_packed
            assign w_evt[gi] = (r_esel[2*gi +: 2] == 2'b00) ? w_rise[gi] :
                               (r_esel[2*gi +: 2] == 2'b01) ? w_fall[gi] :
                               (r_esel[2*gi +: 2] == 2'b10) ? (w_rise[gi] | w_fall[gi]) :
                               1'b0;
        end else begin : g_rise_only
            assign w_evt[gi] = w_rise[gi];
        end
    end

    assign w_det = w_evt & {WIDTH{r_arm[ARM_W-1]}};
    assign w_clr = (avs_write && avs_address == 2'd2) ? avs_writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            2'd0: w_rdata[WIDTH-1:0] = w_cur;
            2'd1: w_rdata[WIDTH-1:0] = r_mask;
            2'd2: w_rdata[WIDTH-1:0] = r_cap;
            default: w_rdata = r_esel;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev       <= '0;
            r_cap        <= '0;
            r_mask       <= '0;
            r_esel       <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            r_prev <= w_cur;
            // A new edge in the same cycle as its W1C wins over the clear.
            r_cap  <= (r_cap & ~w_clr) | w_det;
            irq    <= |(r_cap & r_mask);
            if (avs_write) begin
                case (avs_address)
                    2'd1: r_mask <= avs_writedata[WIDTH-1:0];
                    2'd3: r_esel <= avs_writedata;
                    default: ;
                endcase
            end
            if (avs_read) avs_readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_pio_in_capture.sv
// Scoreboarded bench for pio_in_capture; read expectations are queued at issue and
// checked when avs_readdata becomes valid one cycle later.
module tb_pio_in_capture;

    localparam int unsigned W = 8;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned DEB  = 4;
    localparam int          PIPE = 3 + DEB;  // pin drive to filtered value
    localparam int          WARM = 3;        // reset release to valid DATA read issue
`else
    localparam int unsigned DEB  = 24000;
    localparam int          PIPE = 2;
    localparam int          WARM = 2;
`endif

    logic          clk;
    logic          reset;
    logic [W-1:0]  pins_in;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          irq;

    int            n_cmp;
    int            n_err;
    logic [31:0]   sb[$];
    string         tq[$];

    pio_in_capture #(
        .WIDTH      (W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pins_in       (pins_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic issued;
        issued = avs_read;
        @(posedge clk);
        #1;
        if (issued) begin
            if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 32'd1);
            else check(tq.pop_front(), avs_readdata, sb.pop_front());
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic bus(input logic rd_en, input logic wr_en, input logic [1:0] a,
                       input logic [31:0] d, input logic [31:0] exp, input string tag);
        avs_read      = rd_en;
        avs_write     = wr_en;
        avs_address   = a;
        avs_writedata = d;
        if (rd_en) begin
            sb.push_back(exp);
            tq.push_back(tag);
        end
        step();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus(1'b1, 1'b0, a, 32'h0, exp, tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d, 32'h0, "");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        pins_in = '0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        steps(3);
        reset = 1'b0;
        steps(WARM + 2);

        // 1: build up state, then reset mid-stream with all pins high.
        wr(2'd1, 32'hFF);
        pins_in = 8'hFF;
        steps(PIPE + 3);
        check("pre_rst_irq", {31'b0, irq}, 32'd1);
        rd(2'd0, 32'hFF, "pre_rst_data");
        #2;
        reset = 1'b1;
        #1;
        check("rst_rdata", avs_readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        steps(2);
        reset = 1'b0;
        steps(WARM);
        rd(2'd0, 32'hFF, "post_rst_data");
        wr(2'd1, 32'hFF);
        steps(4);
        rd(2'd2, 32'h0, "post_rst_edge");
        check("post_rst_irq", {31'b0, irq}, 32'd0);

        // 2: rising edge on pin0, irq, then W1C.
        wr(2'd3, 32'h0);
        wr(2'd1, 32'h01);
        pins_in = 8'h00;
        steps(PIPE + 3);
        wr(2'd2, 32'hFF);
        step();
        check("t2_idle_irq", {31'b0, irq}, 32'd0);
        pins_in = 8'h01;
        steps(PIPE + 1);  // capture edge
        check("t2_irq_lat", {31'b0, irq}, 32'd0);
        step();
        check("t2_irq_set", {31'b0, irq}, 32'd1);
        rd(2'd2, 32'h1, "t2_edge");
        wr(2'd2, 32'h1);
        check("t2_irq_hold", {31'b0, irq}, 32'd1);
        step();
        check("t2_irq_drop", {31'b0, irq}, 32'd0);

        // 3: falling-only select on pin3, masked off, then unmasked.
        wr(2'd3, 32'h40);
        pins_in = 8'h09;
        steps(PIPE + 3);
        rd(2'd2, 32'h0, "t3_rise_ign");
        pins_in = 8'h01;
        steps(PIPE + 3);
        rd(2'd2, 32'h8, "t3_fall");
        check("t3_masked_irq", {31'b0, irq}, 32'd0);
        pins_in = 8'h09;
        steps(PIPE + 3);
        rd(2'd2, 32'h8, "t3_sticky");
        wr(2'd1, 32'h08);
        check("t3_irq_wait", {31'b0, irq}, 32'd0);
        step();
        check("t3_irq_set", {31'b0, irq}, 32'd1);
        wr(2'd1, 32'h0);
        wr(2'd2, 32'hFF);
        step();
        check("t3_clean_irq", {31'b0, irq}, 32'd0);

        // 4: both-edges select on pin5; W1C lands on the capture edge.
        wr(2'd3, 32'h800);
        pins_in = 8'h29;
        steps(PIPE);
        wr(2'd2, 32'h20);
        rd(2'd2, 32'h20, "t4_set_wins");
        wr(2'd2, 32'h20);
        rd(2'd2, 32'h0, "t4_cleared");
        pins_in = 8'h09;
        steps(PIPE + 2);
        rd(2'd2, 32'h20, "t4_fall");

        // 5: back-to-back reads, hold, ignored DATA write, read/write collision.
        rd(2'd0, 32'h09, "t5_data");
        rd(2'd1, 32'h00, "t5_mask");
        rd(2'd2, 32'h20, "t5_edge");
        rd(2'd3, 32'h800, "t5_esel");
        step();
        check("t5_hold", avs_readdata, 32'h800);
        wr(2'd0, 32'hFFFF);
        rd(2'd0, 32'h09, "t5_data_ro");
        bus(1'b1, 1'b1, 2'd1, 32'hAA, 32'h00, "t5_rw_old");
        rd(2'd1, 32'hAA, "t5_rw_new");
        check("t5_irq", {31'b0, irq}, 32'd1);

`ifdef PIO_IN_DEBOUNCE_EN
        // 6: a 3-cycle glitch is filtered, a 10-cycle pulse is not.
        pins_in = 8'h0B;
        steps(3);
        pins_in = 8'h09;
        steps(10);
        rd(2'd0, 32'h09, "t6_glitch_data");
        rd(2'd2, 32'h20, "t6_glitch_edge");
        pins_in = 8'h0B;
        steps(10);
        rd(2'd0, 32'h0B, "t6_pulse_data");
        pins_in = 8'h09;
        rd(2'd2, 32'h22, "t6_pulse_edge");
`endif

        steps(2);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
